// File: rtl/bus_ram.sv
// Word-organised RAM slave with a fixed per-access wait count, byte/half/word stores
// and fault reporting. One request in flight; completion is a one-cycle ack pulse.
module bus_ram #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_bus_we,
  input  logic [1:0]  i_bus_size,
  input  logic [31:0] i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  output logic [31:0] o_bus_rdata,
  output logic        o_bus_ack,
  output logic        o_bus_err,
  output logic [1:0]  o_dbg_state
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LAT       = 4'(LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]   off;
  logic          in_range;
  logic          misaligned;
  logic          fault;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic          resp;
  logic          wr_en;

  // Handshake: the core raises i_bus_en with a request and holds it until the
  // o_bus_ack pulse; dropping it while waiting abandons the access silently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (i_bus_en) begin
          we_d    = i_bus_we;
          size_d  = i_bus_size;
          addr_d  = i_bus_addr;
          wdata_d = i_bus_wdata;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!i_bus_en) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Range check on the offset avoids overflow when the window ends at 4 GiB.
  always_comb begin
    off        = addr_q - ADDR_BASE;
    in_range   = (addr_q >= ADDR_BASE) && ({1'b0, off} < WIN_BYTES);
    misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                 ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
    fault      = (size_q == 2'b11) || misaligned || !in_range;
    idx        = off[AW+1:2];
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    case (size_q)
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be     = 4'b1111;
        wlanes = wdata_q;
      end
      default: begin
        be     = 4'b0000;
        wlanes = wdata_q;
      end
    endcase
  end

  assign resp  = (state_q == RESP);
  assign wr_en = resp && we_q && !fault && !i_rst;

  // The store lands on the edge that ends RESP, so a following load sees it.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign o_bus_ack   = resp;
  assign o_bus_err   = resp && fault;
  assign o_bus_rdata = (resp && !we_q && !fault) ? mem[idx] : 32'd0;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bus_ram.sv
// Bench for bus_ram: two instances (LATENCY=2 at base 0, LATENCY=0 at a non-zero
// base) checked against a byte-addressed reference memory.
module tb_bus_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en    [2];
  logic        we    [2];
  logic [1:0]  sz    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic [1:0]  dbg   [2];

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mb [2][4096];

  bus_ram #(.ADDR_BASE(32'h0000_0000), .MEM_WORDS(1024), .LATENCY(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_bus_en(en[0]), .i_bus_we(we[0]), .i_bus_size(sz[0]),
    .i_bus_addr(addr[0]), .i_bus_wdata(wdata[0]), .o_bus_rdata(rdata[0]),
    .o_bus_ack(ack[0]), .o_bus_err(err[0]), .o_dbg_state(dbg[0])
  );

  bus_ram #(.ADDR_BASE(32'h1000_0000), .MEM_WORDS(16), .LATENCY(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_bus_en(en[1]), .i_bus_we(we[1]), .i_bus_size(sz[1]),
    .i_bus_addr(addr[1]), .i_bus_wdata(wdata[1]), .o_bus_rdata(rdata[1]),
    .o_bus_ack(ack[1]), .o_bus_err(err[1]), .o_dbg_state(dbg[1])
  );

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h1000_0000;
  endfunction

  function automatic int unsigned words_of(input int d);
    return (d == 0) ? 1024 : 16;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Reference: memory is a flat byte array; an access of 2**size bytes must be
  // naturally aligned and lie inside the window, loads return the aligned word.
  function automatic void model(input int d, input logic w, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] r);
    logic [31:0] b;
    logic [31:0] off;
    int unsigned n;
    b   = base_of(d);
    n   = 1 << s;
    off = a - b;
    e   = (s == 2'd3) || ((a % n) != 0) || (a < b) || (off >= 4 * words_of(d));
    r   = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < int'(n); i++) mb[d][int'(off[11:0]) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mb[d][int'({off[11:2], 2'b00}) + i];
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive(input int d, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] wd);
    en[d] = 1'b1; we[d] = w; sz[d] = s; addr[d] = a; wdata[d] = wd;
  endtask

  task automatic garble(input int d);
    we[d] = 1'($urandom_range(0, 1)); sz[d] = 2'($urandom_range(0, 3));
    addr[d] = $urandom; wdata[d] = $urandom;
  endtask

  task automatic wait_ack(input int d, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) garble(d);
    end while (!ack[d] && n < 40);
  endtask

  task automatic check_quiet(input int d, input string tag);
    chk({tag, ".ack0"},   32'(ack[d]), 32'd0);
    chk({tag, ".err0"},   32'(err[d]), 32'd0);
    chk({tag, ".rdata0"}, rdata[d],    32'd0);
  endtask

  // Full access: request now, expect ack after LATENCY+1 cycles, then one idle cycle.
  task automatic access(input int d, input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] wd, input string tag, output logic [31:0] obs);
    logic e;
    logic [31:0] r;
    int n;
    model(d, w, s, a, wd, e, r);
    drive(d, w, s, a, wd);
    wait_ack(d, n);
    chk({tag, ".lat"}, 32'(n), 32'(lat_of(d) + 1));
    chk({tag, ".err"}, 32'(err[d]), 32'(e));
    obs = rdata[d];
    if (!w || e) begin
      exp_q.push_back(r);
      chk({tag, ".rdata"}, rdata[d], exp_q.pop_front());
    end
    en[d] = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".after"}, 32'(ack[d]), 32'd0);
  endtask

  task automatic rand_access(input int d, input int k);
    logic [31:0] a;
    logic [31:0] obs;
    logic [1:0]  s;
    int          r;
    r = $urandom_range(0, 7);
    s = (r == 7) ? 2'd3 : 2'(r % 3);
    case ($urandom_range(0, 9))
      8:       a = (d == 0) ? 32'h0000_1000 + $urandom_range(0, 7) : 32'h0FFF_FFFC + $urandom_range(0, 3);
      9:       a = (d == 0) ? 32'hFFFF_FFFC : 32'h1000_0040 + $urandom_range(0, 7);
      default: a = base_of(d) + $urandom_range(0, 63);
    endcase
    access(d, 1'($urandom_range(0, 1)), s, a, $urandom, $sformatf("rnd%0d_%0d", d, k), obs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs;
    logic        e;
    logic [31:0] r;
    logic [31:0] bb_a [6];
    int          n;

    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; we[d] = 1'b0; sz[d] = 2'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_quiet(0, "reset_a");
    check_quiet(1, "reset_b");
    rst = 1'b0;

    // Basic store/load, sub-word stores
    access(0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, "st_w10", obs);
    access(0, 1'b0, 2'd2, 32'h10, 32'h0, "ld_w10", obs);
    chk("spec_w10", obs, 32'hDEAD_BEEF);
    access(0, 1'b1, 2'd0, 32'h12, 32'h0000_0055, "st_b12", obs);
    access(0, 1'b0, 2'd2, 32'h10, 32'h0, "ld_b12", obs);
    chk("spec_b12", obs, 32'hDE55_BEEF);
    access(0, 1'b1, 2'd1, 32'h12, 32'hFFFF_1234, "st_h12", obs);
    access(0, 1'b0, 2'd2, 32'h10, 32'h0, "ld_h12", obs);
    chk("spec_h12", obs, 32'h1234_BEEF);

    // Faults
    access(0, 1'b1, 2'd2, 32'h11, 32'h1111_1111, "flt_w11", obs);
    access(0, 1'b1, 2'd1, 32'h13, 32'h2222_2222, "flt_h13", obs);
    access(0, 1'b1, 2'd3, 32'h10, 32'h3333_3333, "flt_sz3", obs);
    access(0, 1'b0, 2'd2, 32'h1000, 32'h0, "flt_oob", obs);
    access(0, 1'b0, 2'd2, 32'h10, 32'h0, "ld_postflt", obs);
    chk("spec_postflt", obs, 32'h1234_BEEF);

    // Abort in the second wait cycle
    access(0, 1'b1, 2'd2, 32'h20, 32'hA5A5_0020, "pre20", obs);
    drive(0, 1'b1, 2'd2, 32'h20, 32'h0BAD_0020);
    @(posedge clk); #1;
    chk("abort.w1", 32'(ack[0]), 32'd0);
    @(posedge clk); #1;
    chk("abort.w2", 32'(ack[0]), 32'd0);
    en[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort.noack%0d", i), 32'(ack[0]), 32'd0);
    end
    access(0, 1'b0, 2'd2, 32'h20, 32'h0, "ld20", obs);
    chk("spec_abort20", obs, 32'hA5A5_0020);

    // Reset during WAIT of a store
    access(0, 1'b1, 2'd2, 32'h30, 32'h3030_3030, "pre30", obs);
    drive(0, 1'b1, 2'd2, 32'h30, 32'hBAD0_0030);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_quiet(0, "rst_wait");
    @(posedge clk); #1;
    check_quiet(0, "rst_hold");
    rst = 1'b0;
    en[0] = 1'b0;
    access(0, 1'b0, 2'd2, 32'h30, 32'h0, "ld30", obs);
    chk("spec_rst30", obs, 32'h3030_3030);
    access(0, 1'b0, 2'd2, 32'h10, 32'h0, "ld10_rst", obs);
    chk("spec_rst10", obs, 32'h1234_BEEF);

    // Reset while a load is responding drops the outputs at once
    drive(0, 1'b0, 2'd2, 32'h10, 32'h0);
    wait_ack(0, n);
    chk("rst_resp.ack", 32'(ack[0]), 32'd1);
    chk("rst_resp.rdata", rdata[0], 32'h1234_BEEF);
    rst = 1'b1;
    #1;
    check_quiet(0, "rst_resp");
    @(posedge clk); #1;
    rst = 1'b0;
    en[0] = 1'b0;
    @(posedge clk); #1;

    // Reset while a store is responding: nothing written
    drive(0, 1'b1, 2'd2, 32'h30, 32'h0BAD_3030);
    wait_ack(0, n);
    chk("rst_st.ack", 32'(ack[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_quiet(0, "rst_st");
    @(posedge clk); #1;
    rst = 1'b0;
    en[0] = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b0, 2'd2, 32'h30, 32'h0, "ld30b", obs);
    chk("spec_rst_st30", obs, 32'h3030_3030);

    // Randomized traffic on both instances over preloaded words
    for (int i = 0; i < 16; i++) access(0, 1'b1, 2'd2, 32'(4 * i), $urandom, "pre_a", obs);
    for (int k = 0; k < 60; k++) rand_access(0, k);
    for (int i = 0; i < 16; i++) access(1, 1'b1, 2'd2, 32'h1000_0000 + 32'(4 * i), $urandom, "pre_b", obs);
    for (int k = 0; k < 40; k++) rand_access(1, k);

    // Zero latency, request held high: ack every second cycle
    for (int k = 0; k < 6; k++) bb_a[k] = 32'h1000_0000 + 32'(4 * $urandom_range(0, 15));
    drive(1, 1'b0, 2'd2, bb_a[0], 32'h0);
    for (int k = 0; k < 6; k++) begin
      model(1, 1'b0, 2'd2, bb_a[k], 32'h0, e, r);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.ack", k), 32'(ack[1]), 32'd1);
      chk($sformatf("b2b%0d.err", k), 32'(err[1]), 32'(e));
      exp_q.push_back(r);
      chk($sformatf("b2b%0d.rdata", k), rdata[1], exp_q.pop_front());
      if (k < 5) addr[1] = bb_a[k + 1];
      else en[1] = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.gap", k), 32'(ack[1]), 32'd0);
      chk($sformatf("b2b%0d.gap_rdata", k), rdata[1], 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_ram.md
BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, base byte address of the RAM window.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, RAM depth in 32-bit words (power of two, >=4).
REQ-003 SHALL have parameter LATENCY, default 2, added wait cycles per access (0..15).
REQ-004 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_bus_en  input  1  request valid, held by the core until ack.
REQ-007 SHALL have port i_bus_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port i_bus_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port i_bus_addr  input  32  byte address.
REQ-010 SHALL have port i_bus_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port o_bus_rdata  output  32  full aligned RAM word for loads; the core does lane select and sign extension.
REQ-012 SHALL have port o_bus_ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port o_bus_err  output  1  access fault, valid only with o_bus_ack.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 IDLE: i_bus_en=1 SHALL capture we, size, addr and wdata, load the counter with LATENCY, and go to WAIT (LATENCY>0) or RESP (LATENCY=0).
REQ-016 WAIT: the counter SHALL decrement each cycle; at 1 the FSM SHALL go to RESP.
REQ-017 WAIT: i_bus_en=0 SHALL abort the access and return to IDLE, with no write and no ack.
REQ-018 RESP: o_bus_ack=1 for exactly one cycle, then IDLE; ack therefore appears LATENCY+1 cycles after the request cycle.
REQ-019 i_bus_en still high in the cycle after ack SHALL be treated as a new request, accepted in IDLE.
REQ-020 Inputs SHALL be ignored after capture; only i_bus_en is monitored in WAIT.
REQ-021 Fault conditions SHALL be:
  - size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr outside [ADDR_BASE, ADDR_BASE+4*MEM_WORDS-1].
REQ-022 A faulting access SHALL set o_bus_err=1 with ack, perform no write, and drive rdata=0.
REQ-023 Word index SHALL be (addr-ADDR_BASE)[log2(MEM_WORDS)+1:2].
REQ-024 Store byte enables SHALL be:
  - byte: lane addr[1:0], data wdata[7:0];
  - half: lanes {addr[1],0}..{addr[1],1}, data wdata[15:0];
  - word: all lanes.
  Other lanes SHALL be unchanged.
REQ-025 A store SHALL commit on the clock edge ending the RESP cycle.
REQ-026 Load rdata SHALL be valid in the RESP cycle and SHALL be 0 in all other cycles.
REQ-027 Loads SHALL have no side effects.
REQ-028 A load in the cycle directly after a store to the same word SHALL return the new data.

Reset
REQ-029 Assertion of i_rst SHALL immediately:
  - force IDLE;
  - set o_bus_ack=0, o_bus_err=0, o_bus_rdata=0;
  - clear the counter and captured request.
REQ-030 Reset mid-access SHALL discard the pending store; no partial write.
REQ-031 RAM contents SHALL NOT be cleared by reset.
REQ-032 The first request SHALL be accepted on the first rising edge with i_rst=0.

Verification
REQ-033 LATENCY=2, store word 0xDEADBEEF @0x10 then load @0x10 -> ack 3 cycles after each request, err=0, rdata=0xDEADBEEF.
REQ-034 After REQ-033, store byte 0x55 @0x12, then load @0x10 -> rdata=0xDE55BEEF; half store 0x1234 @0x12, then load -> 0x1234BEEF.
REQ-035 Word store @0x11, half @0x13, size=11, load @ADDR_BASE+4*MEM_WORDS -> each acked with err=1, rdata=0, and word @0x10 unchanged.
REQ-036 Store @0x20 with i_bus_en dropped in the 2nd WAIT cycle -> no ack, mem @0x20 unchanged; next request serviced normally.
REQ-037 Store @0x30 with i_rst pulsed during WAIT -> outputs 0 same cycle, no write @0x30, and prior RAM data @0x10 retained.
REQ-038 LATENCY=0, back-to-back loads with i_bus_en held high -> ack every 2nd cycle, correct rdata each.
